// File: rtl/ecc_scrub_regfile.sv
// ecc_scrub_regfile: SECDED register file (write/inject/2-cycle read ports, error counters, sticky uncorrectable flag) with a background scrub FSM
module ecc_scrub_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CNT_W = 16,
  localparam int Q = $clog2(DATA_W + 1),
  localparam int P = (2 ** Q >= DATA_W + Q + 1) ? Q : Q + 1,
  localparam int N = DATA_W + P,
  localparam int CW = N + 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err_corr,
  output logic              rd_err_uncorr,
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [CW-1:0]     inj_mask,
  input  logic              scrub_en,
  output logic              scrub_busy,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              clr_cnt
);
  localparam int WC_W = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, WAIT, READ, CHECK, FIX} state_t;
  typedef struct packed {logic [CW-1:0] cw; logic corr; logic uncorr;} chk_t;
  function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW-1:0] c;
    int j, s;
    c = '0;
    j = 0;
    s = 0;
    for (int i = 1; i <= N; i++) if ((i & (i - 1)) != 0) begin
      c[i] = d[j];
      if (d[j]) s ^= i;
      j++;
    end
    for (int k = 0; k < P; k++) c[1 << k] = s[k];
    c[0] = ^c;
    return c;
  endfunction
  function automatic chk_t correct(input logic [CW-1:0] c);
    chk_t r;
    int s;
    s = 0;
    for (int i = 1; i <= N; i++) if (c[i]) s ^= i;
    r.cw = c;
    r.corr = 1'b0;
    r.uncorr = 1'b0;
    if (^c) begin
      if (s <= N) begin
        r.corr = 1'b1;
        for (int i = 0; i <= N; i++) if (i == s) r.cw[i] = ~c[i];
      end else r.uncorr = 1'b1;
    end else if (s != 0) r.uncorr = 1'b1;
    return r;
  endfunction
  function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] c);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i <= N; i++) if ((i & (i - 1)) != 0) begin
      d[j] = c[i];
      j++;
    end
    return d;
  endfunction
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic a, input logic b);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{CNT_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  logic [CW-1:0] mem [DEPTH];
  logic rd_v1, dirty;
  logic [CW-1:0] rd_cw1, sc_cw, wr_cw;
  logic [ADDR_W-1:0] rd_a1, ptr, ptr_nxt;
  logic [WC_W-1:0] wcnt;
  state_t state;
  chk_t rd_chk, sc_chk;
  logic wr_hit_ptr, fix_we, step_done, rp_corr, rp_uncorr, sc_corr, sc_uncorr;
  assign wr_cw = encode(wr_data);
  assign rd_chk = correct(rd_cw1);
  assign sc_chk = correct(sc_cw);
  assign wr_hit_ptr = wr_en && wr_addr == ptr;
  assign fix_we = state == FIX && !dirty && !wr_en;
  assign step_done = (state == CHECK && !sc_chk.corr) || (state == FIX && (dirty || wr_hit_ptr || !wr_en));
  assign ptr_nxt = ptr == LAST ? '0 : ptr + ADDR_W'(1);
  assign rp_corr = rd_v1 && rd_chk.corr;
  assign rp_uncorr = rd_v1 && rd_chk.uncorr;
  assign sc_corr = state == CHECK && sc_chk.corr;
  assign sc_uncorr = state == CHECK && sc_chk.uncorr;
  assign scrub_busy = state == READ || state == CHECK || state == FIX;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_v1 <= 1'b0;
      rd_cw1 <= '0;
      rd_a1 <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_err_corr <= 1'b0;
      rd_err_uncorr <= 1'b0;
      state <= IDLE;
      ptr <= '0;
      wcnt <= '0;
      sc_cw <= '0;
      dirty <= 1'b0;
      corr_cnt <= '0;
      uncorr_cnt <= '0;
      err_flag <= 1'b0;
      err_addr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= ((wr_en && wr_addr == ADDR_W'(i)) ? wr_cw : (fix_we && ptr == ADDR_W'(i)) ? sc_chk.cw : mem[i])
                  ^ ((inj_en && inj_addr == ADDR_W'(i)) ? inj_mask : '0);
      rd_v1 <= rd_en;
      rd_cw1 <= mem[rd_addr];
      rd_a1 <= rd_addr;
      rd_valid <= rd_v1;
      rd_data <= extract(rd_chk.cw);
      rd_err_corr <= rp_corr;
      rd_err_uncorr <= rp_uncorr;
      if (clr_cnt) begin
        corr_cnt <= '0;
        uncorr_cnt <= '0;
        err_flag <= 1'b0;
        err_addr <= '0;
      end else begin
        corr_cnt <= sat_add(corr_cnt, rp_corr, sc_corr);
        uncorr_cnt <= sat_add(uncorr_cnt, rp_uncorr, sc_uncorr);
        err_flag <= err_flag | rp_uncorr | sc_uncorr;
        err_addr <= rp_uncorr ? rd_a1 : sc_uncorr ? ptr : err_addr;
      end
      if (step_done) begin
        ptr <= ptr_nxt;
        wcnt <= '0;
        state <= scrub_en ? WAIT : IDLE;
      end else begin
        case (state)
          IDLE: begin
            wcnt <= '0;
            if (scrub_en) state <= WAIT;
          end
          WAIT: begin
            if (!scrub_en) state <= IDLE;
            else if (wcnt == WAIT_LAST) state <= READ;
            else wcnt <= wcnt + WC_W'(1);
          end
          READ: begin
            sc_cw <= mem[ptr];
            dirty <= wr_hit_ptr;
            state <= CHECK;
          end
          CHECK: begin
            dirty <= dirty | wr_hit_ptr;
            state <= FIX;
          end
          FIX: state <= FIX;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ecc_scrub_regfile.sv
// tb_ecc_scrub_regfile: directed plus randomized checks of ecc_scrub_regfile against a data/fault-mask reference model
module tb_ecc_scrub_regfile;
  localparam int DW = 32, DEP = 8, SI = 4, CNTW = 2, CWT = 39, AW = 3;
  logic clk = 1'b0, reset, wr_en, rd_en, inj_en, scrub_en, clr_cnt;
  logic [AW-1:0] wr_addr, rd_addr, inj_addr, err_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [CWT-1:0] inj_mask;
  logic rd_valid, rd_err_corr, rd_err_uncorr, scrub_busy, err_flag;
  logic [CNTW-1:0] corr_cnt, uncorr_cnt;
  ecc_scrub_regfile #(.DATA_W(DW), .DEPTH(DEP), .SCRUB_INTERVAL(SI), .CNT_W(CNTW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err_corr(rd_err_corr), .rd_err_uncorr(rd_err_uncorr), .inj_en(inj_en),
    .inj_addr(inj_addr), .inj_mask(inj_mask), .scrub_en(scrub_en), .scrub_busy(scrub_busy),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .err_flag(err_flag), .err_addr(err_addr),
    .clr_cnt(clr_cnt));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int dpos [DW];
  logic [DW-1:0] mdata [DEP];
  logic [CWT-1:0] mmask [DEP];
  int ecorr, euncorr;
  logic eflag;
  logic [AW-1:0] eaddr;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic int sat(input int x);
    return x > 3 ? 3 : x;
  endfunction
  function automatic logic [DW-1:0] raw(input logic [DW-1:0] d, input logic [CWT-1:0] m);
    logic [DW-1:0] r;
    r = d;
    for (int j = 0; j < DW; j++) if (m[dpos[j]]) r[j] = ~r[j];
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    for (int i = 0; i < DEP; i++) begin
      mdata[i] = '0;
      mmask[i] = '0;
    end
    ecorr = 0;
    euncorr = 0;
    eflag = 1'b0;
    eaddr = '0;
  endtask
  task automatic do_write(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
    mdata[a] = d;
    mmask[a] = '0;
  endtask
  task automatic do_inj(input int a, input logic [CWT-1:0] m);
    inj_en = 1'b1;
    inj_addr = AW'(a);
    inj_mask = m;
    step();
    inj_en = 1'b0;
    mmask[a] ^= m;
  endtask
  task automatic do_clr();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    ecorr = 0;
    euncorr = 0;
    eflag = 1'b0;
    eaddr = '0;
  endtask
  task automatic do_read(input int a);
    int n;
    rd_en = 1'b1;
    rd_addr = AW'(a);
    step();
    rd_en = 1'b0;
    chk("rd_valid_early", rd_valid, 0);
    step();
    n = $countones(mmask[a]);
    if (n == 1) ecorr = sat(ecorr + 1);
    if (n == 2) begin
      euncorr = sat(euncorr + 1);
      eflag = 1'b1;
      eaddr = AW'(a);
    end
    chk("rd_valid", rd_valid, 1);
    chk("rd_data", rd_data, n == 2 ? raw(mdata[a], mmask[a]) : mdata[a]);
    chk("rd_err_corr", rd_err_corr, n == 1);
    chk("rd_err_uncorr", rd_err_uncorr, n == 2);
    chk("corr_cnt", corr_cnt, ecorr);
    chk("uncorr_cnt", uncorr_cnt, euncorr);
    chk("err_flag", err_flag, eflag);
    chk("err_addr", err_addr, eaddr);
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_flags"}, {rd_err_corr, rd_err_uncorr, err_flag}, 0);
    chk({tag, "_busy"}, scrub_busy, 0);
    chk({tag, "_cnts"}, {corr_cnt, uncorr_cnt}, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
  endtask
  task automatic wait_busy(input logic level);
    for (int i = 0; i < 40 && scrub_busy !== level; i++) step();
    chk("scrub_busy_wait", scrub_busy, level);
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [CWT-1:0] m;
    int j, op, a;
    j = 0;
    for (int p = 1; p < CWT; p++) if ((p & (p - 1)) != 0) begin
      dpos[j] = p;
      j++;
    end
    {wr_en, rd_en, inj_en, scrub_en, clr_cnt} = '0;
    wr_addr = '0; rd_addr = '0; inj_addr = '0; wr_data = '0; inj_mask = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_reset();
    check_idle_outputs("reset");
    do_write(3, 32'hDEADBEEF);
    do_read(3);
    do_write(1, 32'h12345678);
    do_inj(1, CWT'(1) << 5);
    do_read(1);
    do_clr();
    do_write(1, 32'h12345678);
    do_inj(1, CWT'(1));
    do_read(1);
    do_inj(2, (CWT'(1) << 3) | (CWT'(1) << 9));
    do_read(2);
    chk("double_raw_data", rd_data, 32'h11);
    do_clr();
    chk("clr_cnts", {corr_cnt, uncorr_cnt}, 0);
    chk("clr_err_flag", err_flag, 0);
    for (int k = 0; k < 5; k++) begin
      do_write(4, $urandom);
      do_inj(4, CWT'(1) << $urandom_range(0, CWT - 1));
      do_read(4);
    end
    chk("corr_sat", corr_cnt, 3);
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      a = $urandom_range(0, DEP - 1);
      if (op < 3) do_write(a, $urandom);
      else if (op < 6 && $countones(mmask[a]) < 2) begin
        m = '0;
        m[$urandom_range(0, CWT - 1)] = 1'b1;
        do_inj(a, m);
      end else if (op == 6) do_clr();
      else do_read(a);
    end
    for (int i = 0; i < DEP; i++) do_write(i, $urandom);
    do_clr();
    do_inj(6, CWT'(1) << 7);
    scrub_en = 1'b1;
    repeat (80) step();
    scrub_en = 1'b0;
    wait_busy(1'b0);
    step();
    chk("scrub_corr_cnt", corr_cnt, 1);
    chk("scrub_uncorr_cnt", uncorr_cnt, 0);
    mmask[6] = '0;
    ecorr = 1;
    do_read(6);
    pulse_reset();
    do_inj(0, CWT'(1) << 5);
    scrub_en = 1'b1;
    wait_busy(1'b1);
    step();
    do_write(0, 32'hCAFE0042);
    scrub_en = 1'b0;
    wait_busy(1'b0);
    step();
    ecorr = 1;
    chk("collide_corr_cnt", corr_cnt, 1);
    do_read(0);
    pulse_reset();
    for (int i = 0; i < DEP; i++) do_write(i, $urandom | 32'h1);
    do_inj(0, CWT'(1) << 5);
    scrub_en = 1'b1;
    wait_busy(1'b1);
    step();
    step();
    chk("fix_busy", scrub_busy, 1);
    chk("fix_corr_cnt", corr_cnt, 1);
    reset = 1'b1;
    scrub_en = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
    check_idle_outputs("midfix");
    for (int i = 0; i <= DEP; i++) begin
      rd_en = i < DEP;
      rd_addr = AW'(i);
      step();
      if (i >= 1) begin
        chk("b2b_valid", rd_valid, 1);
        chk("b2b_data", rd_data, 0);
        chk("b2b_flags", {rd_err_corr, rd_err_uncorr}, 0);
      end
    end
    rd_en = 1'b0;
    step();
    chk("b2b_pulse_end", rd_valid, 0);
    chk("b2b_cnts", {corr_cnt, uncorr_cnt}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ecc_scrub_regfile.md
# ecc_scrub_regfile

Parametrised SECDED-protected register file with a background scrubber. It generalises the fixed 8/32-bit Hamming encode/recover pair into one block: any data width, extended (double-error-detecting) code, DEPTH storage entries, and registered read decode. A scrub FSM periodically walks all entries and writes back corrected codewords. It holds CPU-state and operand values that must survive single-event upsets.

## Interface
- DATA_W, 32, data bits per entry (≥4)
- DEPTH, 8, number of entries (≥2)
- SCRUB_INTERVAL, 256, idle cycles between scrub steps (≥1)
- CNT_W, 16, error counter width
- Derived: P = smallest integer with 2^P ≥ DATA_W+P+1; N = DATA_W+P; CW = N+1; ADDR_W = $clog2(DEPTH)

Ports:
- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- wr_en / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  write port
- rd_en / rd_addr  in  1 / ADDR_W  read request
- rd_valid  out  1  read result valid
- rd_data  out  DATA_W  corrected data
- rd_err_corr / rd_err_uncorr  out  1 / 1  result classification, qualified by rd_valid
- inj_en / inj_addr / inj_mask  in  1 / ADDR_W / CW  XOR fault injection into a stored codeword
- scrub_en  in  1  enable background scrubbing
- scrub_busy  out  1  scrub FSM not in IDLE/WAIT
- corr_cnt / uncorr_cnt  out  CNT_W / CNT_W  saturating error counters
- err_flag  out  1  sticky: any uncorrectable error seen
- err_addr  out  ADDR_W  address of the most recent uncorrectable error
- clr_cnt  in  1  clears counters, err_flag, err_addr

## Operation
- Code layout: Hamming positions 1..N occupy codeword bits 1..N. Parity bits sit at power-of-two positions. Data bits fill the remaining positions in ascending order (data[0] at position 3). Bit 0 holds the overall even parity of bits 1..N.
- For DATA_W=32: P=6, CW=39. For DATA_W=8: P=4, CW=13.
- Decode:
  - S = XOR of the indices of all set bits in 1..N. O = XOR of all CW bits.
  - S=0, O=0: clean.
  - O=1, S≤N: single error. Flip bit S (S=0 means the overall parity bit). Set corr.
  - O=0, S≠0: double error. Set uncorr.
  - O=1, S>N: set uncorr.
  - Whenever uncorr is set, data is the raw, uncorrected data bits.
- Reset: every entry is loaded with the all-zero codeword. All outputs are 0. Scrub pointer is 0. FSM goes to IDLE.
- Write: the entry receives encode(wr_data) at the clock edge.
- Injection: the entry receives stored ^ inj_mask. If a write hits the same address in the same cycle, the entry receives encode(wr_data) ^ inj_mask.
- Scrub FSM states:
  - IDLE → WAIT when scrub_en=1.
  - WAIT: count SCRUB_INTERVAL cycles, then go to READ. If scrub_en drops, go to IDLE at once.
  - READ: register entry[ptr]. Clear the "dirty" flag.
  - CHECK: decode.
    - Clean: ptr++ (mod DEPTH), go to WAIT.
    - Uncorrectable: count it, ptr++, go to WAIT. No writeback.
    - Correctable: go to FIX.
  - FIX: write the corrected codeword back, ptr++, go to WAIT. Rules:
    - User write to the same address in this cycle: drop the fix.
    - User write to a different address in this cycle: hold in FIX.
    - User write to ptr at any point during READ..FIX (dirty flag set): drop the fix.
  - scrub_en drop in READ/CHECK/FIX: finish the current entry, then go to IDLE.
- Counters:
  - corr_cnt and uncorr_cnt count both read-port and scrub detections. Each increments by up to 2 per cycle.
  - Counters saturate at all-ones.
  - clr_cnt wins over a simultaneous increment.
  - Scrub and read-port uncorrectable errors in the same cycle: err_addr takes the read-port address.

## Timing
- Read latency is 2 cycles. rd_en at cycle t gives rd_valid, rd_data and flags at t+2.
  - Stage 1 registers the codeword.
  - Stage 2 registers the decoded result.
  - rd_valid is a 1-cycle pulse per request.
  - Back-to-back reads are supported at one per cycle.
- Read during a write to the same address returns the old contents. The read captures the array before the edge.
- Write-to-read visibility: a write at t is readable by an rd_en at t+1.
- Counters, err_flag and err_addr update in the same cycle that rd_valid asserts (read port), or at the CHECK edge (scrub).
- One scrub step, with no stall, takes READ+CHECK(+FIX): 2–3 cycles after WAIT expires.
- A scrub writeback never coincides with a user write.
- Reset mid-scrub: FSM returns to IDLE, the array is re-zeroed, and no writeback occurs.

## Test plan
- Clean read:
  - Stimulus: write 0xDEADBEEF to addr 3, then rd_en addr 3 one cycle later.
  - Response: rd_valid 2 cycles after rd_en, rd_data=0xDEADBEEF, both flags 0, counters 0.
- Single-bit correction:
  - Stimulus: write 0x12345678 to addr 1, inject mask bit 5, read addr 1.
  - Response: rd_data=0x12345678, rd_err_corr=1, corr_cnt=1.
  - Repeat with inject bit 0 (overall parity): same response.
- Double-bit detection:
  - Stimulus: inject mask bits 3 and 9 on addr 2, read addr 2.
  - Response: rd_err_uncorr=1, uncorr_cnt=1, err_flag=1, err_addr=2.
  - After clr_cnt pulse: counters=0, err_flag=0.
- Scrub repair:
  - Setup: SCRUB_INTERVAL=4, DEPTH=8.
  - Stimulus: inject bit 7 into addr 6, enable scrub, wait one full pass, disable scrub, read addr 6.
  - Response: corr_cnt=1 from scrub. Read returns clean with corr flag 0, and corr_cnt stays 1.
- Scrub/write collision:
  - Stimulus: inject a single error at ptr, then issue a user write to ptr during CHECK.
  - Response: fix dropped; the entry holds the user write and reads back clean.
- Saturation and reset:
  - Setup: CNT_W=2.
  - Stimulus: 5 correctable reads.
  - Response: corr_cnt=3.
  - Stimulus: reset mid-FIX.
  - Response: all outputs 0 and all entries read 0 with no flags.
